spram_arbiter: RTL and testbench

SPRAM_ARBITER -- requirements
Module: spram_arbiter

---
 rtl/spram_arb_pkg.sv | 13 +
 rtl/arb_sel2.sv | 45 ++++
 rtl/spram_arbiter.sv | 159 +++++++++++++++
 tb/tb_spram_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// Shared defaults and FSM state type for the two-port single-port-RAM arbiter.
package spram_arb_pkg;

    localparam int SPRAM_DATA_W = 8;
    localparam int SPRAM_ADDR_W = 6;
    localparam int SPRAM_DEPTH  = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_sel2.sv
// Two-way grant selector: fixed priority (port 0 wins) by default,
// round-robin with an internal priority pointer when SPRAM_ARB_RR_EN is defined.
module arb_sel2 (
`ifdef SPRAM_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic sel0,
    output logic sel1
);

`ifdef SPRAM_ARB_RR_EN
    // prio_q names the port that wins the next contention; it moves away from each winner.
    logic prio_q;
    logic prio_d;

    always_comb begin
        sel0   = en && req0 && (!req1 || !prio_q);
        sel1   = en && req1 && (!req0 ||  prio_q);
        prio_d = prio_q;
        if (sel0) begin
            prio_d = 1'b1;
        end else if (sel1) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    always_comb begin
        sel0 = en && req0;
        sel1 = en && req1 && !req0;
    end
`endif

endmodule

// File: rtl/spram_arbiter.sv
// Arbitrates two request ports onto one single-port RAM; reads take an extra RD_WAIT cycle.
// Define SPRAM_ARB_RR_EN for round-robin arbitration (fixed priority to port 0 otherwise).
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int DATA_W = SPRAM_DATA_W,
    parameter int ADDR_W = SPRAM_ADDR_W,
    parameter int DEPTH  = SPRAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              owner_q;
    logic              owner_d;
    logic              rvalid0_q;
    logic              rvalid0_d;
    logic              rvalid1_q;
    logic              rvalid1_d;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata0_d;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata1_d;

    logic              arb_en;
    logic              p0_sel;
    logic              p1_sel;
    logic              p0_oor;
    logic              p1_oor;
    logic              rd_start;

    // Grants are combinational, so they are gated by rst_n to drop the moment reset asserts.
    assign arb_en = rst_n && (state_q == IDLE);
    assign p0_oor = ({1'b0, p0_addr} >= DEPTH_L);
    assign p1_oor = ({1'b0, p1_addr} >= DEPTH_L);
    assign rd_start = (p0_sel && !p0_we && !p0_oor) || (p1_sel && !p1_we && !p1_oor);

    arb_sel2 u_sel (
`ifdef SPRAM_ARB_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .en    (arb_en),
        .req0  (p0_req),
        .req1  (p1_req),
        .sel0  (p0_sel),
        .sel1  (p1_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p0_gnt    = p0_sel;
        p1_gnt    = p1_sel;
        p0_err    = p0_sel && p0_oor;
        p1_err    = p1_sel && p1_oor;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (p0_sel) begin
            ram_we    = p0_we && !p0_oor;
            ram_addr  = p0_addr;
            ram_wdata = p0_wdata;
        end else if (p1_sel) begin
            ram_we    = p1_we && !p1_oor;
            ram_addr  = p1_addr;
            ram_wdata = p1_wdata;
        end
    end

    // ram_rdata is valid during RD_WAIT; capture it for the owner and flag it next cycle.
    always_comb begin
        owner_d   = owner_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (rd_start) begin
            owner_d = p1_sel;
        end
        if (state_q == RD_WAIT) begin
            if (owner_q) begin
                rvalid1_d = 1'b1;
                rdata1_d  = ram_rdata;
            end else begin
                rvalid0_d = 1'b1;
                rdata0_d  = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            owner_q   <= owner_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign p0_rvalid = rvalid0_q;
    assign p1_rvalid = rvalid1_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: directed scenarios plus a randomized run
// against a transaction-level model; honours SPRAM_ARB_RR_EN like the design.
module tb_spram_arbiter;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int DP = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          mem_clr = 1'b1;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    wire [6:0] flags = {p0_gnt, p1_gnt, p0_err, p1_err, ram_we, p0_rvalid, p1_rvalid};

    always #5 clk = ~clk;

    spram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Single-port RAM with one-cycle read latency, read-before-write
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
    endtask

    task automatic idle_all();
        set_p0(1'b0, 1'b0, '0, '0);
        set_p1(1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_p0(1'b1, 1'b1, 6'd3, 8'h11);
        set_p1(1'b1, 1'b0, 6'd4, 8'h22);
        #2;
        n_cmp++;
        if (flags !== 7'b0) begin
            n_bad++; $display("FAIL reset_flags got=%b want=0000000", flags);
        end
        n_cmp++;
        if ({ram_addr, ram_wdata, p0_rdata, p1_rdata} !== '0) begin
            n_bad++; $display("FAIL reset_data addr=%h wdata=%h rd0=%h rd1=%h want all 0", ram_addr, ram_wdata, p0_rdata, p1_rdata);
        end
        idle_all();
        next();
        rst_n = 1'b1;
    endtask

    task automatic test_write_b2b();
        next(); set_p0(1'b1, 1'b1, 6'd0, 8'h10);
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b1000100 || ram_addr !== 6'd0 || ram_wdata !== 8'h10) begin
            n_bad++; $display("FAIL wr0_grant flags=%b addr=%h wdata=%h want 1000100/00/10", flags, ram_addr, ram_wdata);
        end
        next(); set_p0(1'b1, 1'b1, 6'd7, 8'hAF);
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b1000100 || ram_addr !== 6'd7 || ram_wdata !== 8'hAF) begin
            n_bad++; $display("FAIL wr7_grant flags=%b addr=%h wdata=%h want 1000100/07/af", flags, ram_addr, ram_wdata);
        end
        next(); idle_all();
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            n_bad++; $display("FAIL no_grant_idle flags=%b addr=%h wdata=%h want 0", flags, ram_addr, ram_wdata);
        end
        n_cmp++;
        if (mem[0] !== 8'h10 || mem[7] !== 8'hAF) begin
            n_bad++; $display("FAIL ram_contents m0=%h m7=%h want 10/af", mem[0], mem[7]);
        end
    endtask

    task automatic test_read();
        next(); set_p1(1'b1, 1'b0, 6'd7, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b0100000 || ram_addr !== 6'd7) begin
            n_bad++; $display("FAIL rd1_grant flags=%b addr=%h want 0100000/07", flags, ram_addr);
        end
        next(); set_p1(1'b0, 1'b0, '0, '0); set_p0(1'b1, 1'b1, 6'd3, 8'h55);
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b0) begin
            n_bad++; $display("FAIL rd_wait_no_grant flags=%b want 0000000", flags);
        end
        next();
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b1000101 || p1_rdata !== 8'hAF) begin
            n_bad++; $display("FAIL rd1_rvalid flags=%b rdata1=%h want 1000101/af", flags, p1_rdata);
        end
        next(); idle_all();
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b0 || p1_rdata !== 8'hAF) begin
            n_bad++; $display("FAIL rd1_hold flags=%b rdata1=%h want 0000000/af", flags, p1_rdata);
        end
    endtask

    task automatic test_contention();
        int c0 = 0;
        int c1 = 0;
        logic [1:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next();
            set_p0(1'b1, 1'b1, 6'(8 + c0), 8'(8'h20 + c0));
            set_p1(1'b1, 1'b1, 6'(16 + c1), 8'(8'h30 + c1));
`ifdef SPRAM_ARB_RR_EN
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            want = 2'b10;
`endif
            @(negedge clk);
            n_cmp++;
            if ({p0_gnt, p1_gnt} !== want || ram_addr !== (want[1] ? 6'(8 + c0) : 6'(16 + c1))) begin
                n_bad++; $display("FAIL contention_%0d gnt=%b addr=%h want gnt=%b", i, {p0_gnt, p1_gnt}, ram_addr, want);
            end
            if (want[1]) c0++; else c1++;
        end
        next(); set_p0(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        n_cmp++;
        if ({p0_gnt, p1_gnt} !== 2'b01 || ram_addr !== 6'(16 + c1)) begin
            n_bad++; $display("FAIL loser_granted gnt=%b addr=%h want 01/%h", {p0_gnt, p1_gnt}, ram_addr, 6'(16 + c1));
        end
        next(); idle_all();
    endtask

    task automatic test_out_of_range();
        next(); set_p0(1'b1, 1'b0, 6'd0, 8'h00);
        next(); idle_all();
        next();
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b0000010 || p0_rdata !== 8'h10) begin
            n_bad++; $display("FAIL rd0_in_range flags=%b rdata0=%h want 0000010/10", flags, p0_rdata);
        end
        next(); set_p0(1'b1, 1'b0, 6'd40, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b1010000) begin
            n_bad++; $display("FAIL oor_read flags=%b want 1010000", flags);
        end
        for (int k = 0; k < 2; k++) begin
            next(); idle_all();
            @(negedge clk);
            n_cmp++;
            if (flags !== 7'b0 || p0_rdata !== 8'h10) begin
                n_bad++; $display("FAIL oor_no_rvalid_%0d flags=%b rdata0=%h want 0000000/10", k, flags, p0_rdata);
            end
        end
        next(); set_p1(1'b1, 1'b1, 6'd50, 8'h77);
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b0101000) begin
            n_bad++; $display("FAIL oor_write flags=%b want 0101000", flags);
        end
        next(); idle_all();
    endtask

    task automatic test_reset_inflight();
        next(); set_p0(1'b1, 1'b1, 6'd2, 8'h3C);
        next(); set_p0(1'b1, 1'b0, 6'd2, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b1000000) begin
            n_bad++; $display("FAIL inflight_grant flags=%b want 1000000", flags);
        end
        next(); set_p0(1'b1, 1'b1, 6'd5, 8'h99);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (flags !== 7'b0 || {ram_addr, ram_wdata, p0_rdata, p1_rdata} !== '0) begin
            n_bad++; $display("FAIL inflight_reset flags=%b addr=%h wdata=%h rd0=%h rd1=%h want 0", flags, ram_addr, ram_wdata, p0_rdata, p1_rdata);
        end
        next(); idle_all(); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (flags !== 7'b0) begin
                n_bad++; $display("FAIL inflight_discard_%0d flags=%b want 0000000", k, flags);
            end
            next();
        end
        set_p0(1'b1, 1'b1, 6'd5, 8'h99);
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b1000100 || ram_addr !== 6'd5) begin
            n_bad++; $display("FAIL post_reset_grant flags=%b addr=%h want 1000100/05", flags, ram_addr);
        end
        next(); idle_all();
    endtask

    task automatic test_read_then_write();
        next(); set_p1(1'b1, 1'b1, 6'd2, 8'h5A);
        next(); set_p1(1'b1, 1'b0, 6'd2, 8'h00);
        next(); set_p1(1'b0, 1'b0, '0, '0); set_p0(1'b1, 1'b1, 6'd9, 8'h66);
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b0) begin
            n_bad++; $display("FAIL rw_wait flags=%b want 0000000", flags);
        end
        next();
        @(negedge clk);
        n_cmp++;
        if (flags !== 7'b1000101 || p1_rdata !== 8'h5A || ram_addr !== 6'd9) begin
            n_bad++; $display("FAIL rw_handover flags=%b rdata1=%h addr=%h want 1000101/5a/09", flags, p1_rdata, ram_addr);
        end
        next(); idle_all();
    endtask

    // Transaction-level model: a granted in-range read blocks the next cycle and
    // returns the word stored at grant time two cycles later.
    task automatic test_random();
        logic          a [2];
        logic          wr [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        logic [DW-1:0] rmem [1 << AW];
        logic [DW-1:0] erd [2];
        logic [6:0]    ef;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, rv_data;
        bit            busy, rv_pend, oor;
        int            win, rv_port, rv_cyc;
`ifdef SPRAM_ARB_RR_EN
        int            last = 1;
`endif
        next(); mem_clr = 1'b1;
        next(); mem_clr = 1'b0;
        for (int i = 0; i < (1 << AW); i++) rmem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            a[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; wd[p] = '0; erd[p] = '0;
        end
        busy = 0; rv_pend = 0; rv_port = 0; rv_cyc = 0; rv_data = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            next();
            for (int p = 0; p < 2; p++) begin
                if (!a[p] && $urandom_range(0, 2) != 0) begin
                    a[p]  = 1'b1;
                    wr[p] = 1'($urandom_range(0, 1));
                    ad[p] = 6'($urandom_range(0, 39));
                    wd[p] = 8'($urandom);
                end
            end
            set_p0(a[0], wr[0], ad[0], wd[0]);
            set_p1(a[1], wr[1], ad[1], wd[1]);
            @(negedge clk);
            win = -1;
            if (!busy) begin
                if (a[0] && a[1]) begin
`ifdef SPRAM_ARB_RR_EN
                    win = 1 - last;
`else
                    win = 0;
`endif
                end else if (a[0]) win = 0;
                else if (a[1]) win = 1;
            end
            ef = '0; e_addr = '0; e_wd = '0; oor = 0;
            if (win >= 0) begin
                oor = (ad[win] >= 6'(DP));
                ef[6 - win] = 1'b1;
                ef[4 - win] = oor;
                ef[2] = wr[win] && !oor;
                e_addr = ad[win];
                e_wd = wd[win];
            end
            if (rv_pend && rv_cyc == c) begin
                erd[rv_port] = rv_data;
                ef[1 - rv_port] = 1'b1;
                rv_pend = 0;
            end
            n_cmp++;
            if (flags !== ef) begin
                n_bad++; $display("FAIL rand_flags cyc=%0d got=%b want=%b", c, flags, ef);
            end
            n_cmp++;
            if (ram_addr !== e_addr || ram_wdata !== e_wd) begin
                n_bad++; $display("FAIL rand_ram cyc=%0d addr=%h wdata=%h want %h/%h", c, ram_addr, ram_wdata, e_addr, e_wd);
            end
            n_cmp++;
            if (p0_rdata !== erd[0] || p1_rdata !== erd[1]) begin
                n_bad++; $display("FAIL rand_rdata cyc=%0d rd0=%h rd1=%h want %h/%h", c, p0_rdata, p1_rdata, erd[0], erd[1]);
            end
            busy = 0;
            if (win >= 0) begin
                a[win] = 1'b0;
`ifdef SPRAM_ARB_RR_EN
                last = win;
`endif
                if (!oor) begin
                    if (wr[win]) begin
                        rmem[ad[win]] = wd[win];
                    end else begin
                        busy = 1; rv_pend = 1; rv_port = win; rv_cyc = c + 2; rv_data = rmem[ad[win]];
                    end
                end
            end
        end
        next(); idle_all();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;
        test_reset();
        test_write_b2b();
        test_read();
        test_contention();
        test_out_of_range();
        test_reset_inflight();
        test_read_then_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
